reg_wb_arbiter: RTL and testbench

- Owns the single write port of the 16 x 8-bit register file (r0 hardwired to zero) and shares it between two writeback requesters: ALU and memory/load unit.
- After reset, runs an init sequence that writes 0 to r1..r15.
- Keeps a per-register pending-write scoreboard and raises a stall for read-after-write and write-after-write hazards at issue.
- Sits between the issue/decode stage, the execution units and the register file.

---
 rtl/reg_wb_arbiter.sv | 156 +++++++++++++++
 tb/tb_reg_wb_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_arbiter.sv
// Write-port owner for the 16 x 8 register file: post-reset zero-fill, round-robin
// ALU/load writeback arbitration, and a pending-write scoreboard that stalls issue.
module reg_wb_arbiter #(
  parameter int NREG = 16,
  parameter int AW   = 4,
  parameter int DW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_rd,
  input  logic [DW-1:0] mem_data,
  output logic          mem_ready,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_ra,
  input  logic [AW-1:0] issue_rb,
  input  logic [AW-1:0] issue_rd,
  input  logic          issue_wr,
  output logic          stall,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          init_done
);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   init_cnt_q, init_cnt_d;
  logic            rr_q, rr_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic            init_done_q, init_done_d;
  logic            alu_ready_s, mem_ready_s, stall_s;

  // State register for the whole block
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= AW'(1);
      rr_q        <= 1'b0;
      busy_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      rr_q        <= rr_d;
      busy_q      <= busy_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      init_done_q <= init_done_d;
    end
  end

  // Arbitration, write-port sequencing, init counter and scoreboard next state
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    rr_d        = rr_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    init_done_d = init_done_q;
    alu_ready_s = 1'b0;
    mem_ready_s = 1'b0;

    case (state_q)
      ST_INIT: begin
        wr_en_d    = 1'b1;
        wr_addr_d  = init_cnt_q;
        wr_data_d  = '0;
        init_cnt_d = init_cnt_q + AW'(1);
        if (init_cnt_q == AW'(NREG - 1)) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end else begin
          state_d     = ST_INIT;
        end
      end
      ST_RUN: begin
        if (alu_valid && mem_valid) begin
          // Contested: grant per pointer, then point at the loser
          alu_ready_s = !rr_q;
          mem_ready_s = rr_q;
          rr_d        = !rr_q;
        end else begin
          alu_ready_s = alu_valid;
          mem_ready_s = mem_valid;
        end
        if (alu_ready_s) begin
          wr_en_d = (alu_rd != '0);
          if (alu_rd != '0) begin
            wr_addr_d = alu_rd;
            wr_data_d = alu_data;
          end else begin
            wr_addr_d = wr_addr_q;
          end
        end else if (mem_ready_s) begin
          wr_en_d = (mem_rd != '0);
          if (mem_rd != '0) begin
            wr_addr_d = mem_rd;
            wr_data_d = mem_data;
          end else begin
            wr_addr_d = wr_addr_q;
          end
        end else begin
          wr_en_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    stall_s = (state_q == ST_INIT);
    if (issue_valid) begin
      stall_s = stall_s || busy_q[issue_ra] || busy_q[issue_rb] ||
                (issue_wr && busy_q[issue_rd]);
    end else begin
      stall_s = (state_q == ST_INIT);
    end

    // Clear on the register-file capture edge first so a same-edge set wins
    busy_d = busy_q;
    if (wr_en_q) begin
      busy_d[wr_addr_q] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (issue_valid && !stall_s && issue_wr && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
  end

  assign alu_ready = alu_ready_s;
  assign mem_ready = mem_ready_s;
  assign stall     = stall_s;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Scoreboard bench for reg_wb_arbiter: expected register-file writes are queued with
// their due cycle when stimulus is driven and popped by a write-port monitor.
module tb_reg_wb_arbiter;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, mem_valid, issue_valid, issue_wr;
  logic [AW-1:0] alu_rd, mem_rd, issue_ra, issue_rb, issue_rd;
  logic [DW-1:0] alu_data, mem_data;
  logic          alu_ready, mem_ready, stall, wr_en, init_done;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  typedef struct packed {
    logic [31:0]   cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t  exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  logic rr_m = 1'b0;

  reg_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .issue_valid(issue_valid), .issue_ra(issue_ra), .issue_rb(issue_rb),
    .issue_rd(issue_rd), .issue_wr(issue_wr), .stall(stall),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .init_done(init_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Write-port monitor: every wr_en must match the oldest queued write on its due cycle
  always @(negedge clk) begin : mon
    wr_t e;
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("wr_spurious", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_data", 32'(wr_data), 32'(e.data));
        chk("wr_cycle", 32'(cyc), e.cyc);
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc <= 32'(cyc)) begin
      chk("wr_missing", 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Inputs already driven; check grants and stall, queue the resulting write, advance
  task automatic req_cycle(input logic exp_stall);
    logic ea, em;
    #2;
    if (alu_valid && mem_valid) begin
      ea   = !rr_m;
      em   = rr_m;
      rr_m = !rr_m;
    end else begin
      ea = alu_valid;
      em = mem_valid;
    end
    chk("alu_ready", 32'(alu_ready), 32'(ea));
    chk("mem_ready", 32'(mem_ready), 32'(em));
    chk("stall", 32'(stall), 32'(exp_stall));
    if (ea && alu_rd != 4'd0) exp_q.push_back(wr_t'{32'(cyc + 1), alu_rd, alu_data});
    if (em && mem_rd != 4'd0) exp_q.push_back(wr_t'{32'(cyc + 1), mem_rd, mem_data});
    step();
  endtask

  // Release reset and walk the 15 init writes
  task automatic run_init();
    rst = 1'b0;
    for (int i = 1; i <= 15; i++) exp_q.push_back(wr_t'{32'(cyc + i), 4'(i), 8'h00});
    alu_valid = 1'b1;
    mem_valid = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (k == 15) begin
        alu_valid = 1'b0;
        mem_valid = 1'b0;
      end
      #2;
      chk("init_done", 32'(init_done), (k == 15) ? 32'd1 : 32'd0);
      if (k < 15) begin
        chk("init_stall", 32'(stall), 32'd1);
        chk("init_alu_rdy", 32'(alu_ready), 32'd0);
        chk("init_mem_rdy", 32'(mem_ready), 32'd0);
      end else begin
        chk("run_stall", 32'(stall), 32'd0);
      end
    end
    step();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0; issue_wr = 1'b0;
    alu_rd = '0; mem_rd = '0; alu_data = '0; mem_data = '0;
    issue_ra = '0; issue_rb = '0; issue_rd = '0;
    repeat (3) step();
    #2;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_stall", 32'(stall), 32'd1);
    step();
    run_init();

    // ALU alone
    alu_valid = 1'b1; alu_rd = 4'd3; alu_data = 8'hA5;
    req_cycle(1'b0);
    alu_valid = 1'b0;
    req_cycle(1'b0);
    req_cycle(1'b0);

    // Contested: ALU, MEM, ALU, MEM
    alu_valid = 1'b1; alu_rd = 4'd1; alu_data = 8'h11;
    mem_valid = 1'b1; mem_rd = 4'd2; mem_data = 8'h22;
    repeat (4) req_cycle(1'b0);
    alu_valid = 1'b0; mem_valid = 1'b0;
    req_cycle(1'b0);

    // RAW / WAW hazard on r5
    issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 4'd5; issue_ra = 4'd0; issue_rb = 4'd0;
    req_cycle(1'b0);
    issue_wr = 1'b0; issue_rd = 4'd0; issue_ra = 4'd5;
    req_cycle(1'b1);
    req_cycle(1'b1);
    issue_ra = 4'd0; issue_wr = 1'b1; issue_rd = 4'd5;
    req_cycle(1'b1);
    issue_wr = 1'b0; issue_rd = 4'd0; issue_rb = 4'd5;
    req_cycle(1'b1);
    issue_rb = 4'd0; issue_ra = 4'd5;
    alu_valid = 1'b1; alu_rd = 4'd5; alu_data = 8'h5A;
    req_cycle(1'b1);
    alu_valid = 1'b0;
    req_cycle(1'b1);
    req_cycle(1'b0);

    // Writeback to r0 and reads of r0
    issue_ra = 4'd0;
    mem_valid = 1'b1; mem_rd = 4'd0; mem_data = 8'hFF;
    req_cycle(1'b0);
    mem_valid = 1'b0; issue_wr = 1'b1; issue_rd = 4'd0;
    req_cycle(1'b0);
    issue_wr = 1'b0;
    req_cycle(1'b0);
    req_cycle(1'b0);

    // Set and clear of r6 on the same edge: set wins
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 4'd6; alu_data = 8'h66;
    req_cycle(1'b0);
    alu_valid = 1'b0;
    issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 4'd6;
    req_cycle(1'b0);
    issue_wr = 1'b0; issue_rd = 4'd0; issue_ra = 4'd6;
    req_cycle(1'b1);
    alu_valid = 1'b1; alu_rd = 4'd6; alu_data = 8'h67;
    req_cycle(1'b1);
    alu_valid = 1'b0;
    req_cycle(1'b1);
    req_cycle(1'b0);

    // Reset mid-operation with r7 busy and a write in flight
    issue_ra = 4'd0; issue_wr = 1'b1; issue_rd = 4'd7;
    alu_valid = 1'b1; alu_rd = 4'd1; alu_data = 8'h11;
    mem_valid = 1'b1; mem_rd = 4'd2; mem_data = 8'h22;
    req_cycle(1'b0);
    mem_valid = 1'b0; alu_rd = 4'd9; alu_data = 8'h99;
    issue_wr = 1'b0; issue_rd = 4'd0; issue_ra = 4'd7;
    req_cycle(1'b1);
    rst = 1'b1; alu_rd = 4'd10; alu_data = 8'hAA;
    step();
    rr_m = 1'b0;
    #2;
    chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
    chk("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("mid_rst_init_done", 32'(init_done), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd1);
    alu_valid = 1'b0; issue_valid = 1'b0;
    run_init();

    issue_valid = 1'b1; issue_ra = 4'd7; issue_rb = 4'd0; issue_wr = 1'b0;
    alu_valid = 1'b1; alu_rd = 4'd4; alu_data = 8'h44;
    mem_valid = 1'b1; mem_rd = 4'd8; mem_data = 8'h88;
    req_cycle(1'b0);
    alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0;
    req_cycle(1'b0);
    req_cycle(1'b0);

    repeat (2) step();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
